// File: rtl/tic_tac_toe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tic_tac_toe_pkg
// Description : Shared turn-sequencer states, board constants, cell decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package tic_tac_toe_pkg;

    localparam int         NUM_CELLS = 9;
    localparam logic [3:0] MAX_CELL  = 4'd8;

    typedef enum logic [2:0] {
        P1_TURN   = 3'd0,
        ISSUE1    = 3'd1,
        P2_TURN   = 3'd2,
        ISSUE2    = 3'd3,
        CHECK     = 3'd4,
        GAME_OVER = 3'd5
    } state_t;

    function automatic logic [NUM_CELLS-1:0] cell_onehot(input logic [3:0] idx);
        return {{(NUM_CELLS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/commit_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : commit_debouncer
// Description : Synchronizes and debounces the commit switch; emits one pulse
//               per debounced rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module commit_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic commit,
    output logic commit_pulse
);

    localparam logic [CNT_W-1:0] c_count_last = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_count_one  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_count;
    logic             r_level;
    logic             r_pulse;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_count <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= commit;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            if (r_sync2 == r_level) begin
                r_count <= '0;
            end else if (r_count == c_count_last) begin
                // Pulse only when the level flips from released to pressed.
                r_level <= ~r_level;
                r_count <= '0;
                r_pulse <= ~r_level;
            end else begin
                r_count <= r_count + c_count_one;
            end
        end
    end

    assign commit_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/turn_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : turn_sequencer
// Description : Converts cell select + commit into alternating one-hot player
//               write enables, with illegal-move retry and end-of-game freeze.
// Revision    : 1.0 - initial release
// ============================================================================
module turn_sequencer
    import tic_tac_toe_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           cell_sel,
    input  logic                 commit,
    input  logic                 ill_move,
    input  logic                 win,
    input  logic                 no_space,
    output logic [NUM_CELLS-1:0] p1_en,
    output logic [NUM_CELLS-1:0] p2_en,
    output logic                 p1_turn,
    output logic                 p2_turn,
    output logic                 game_over,
    output logic                 illegal,
    output logic                 bad_sel
);

    logic                 w_commit_pulse;
    state_t               r_state;
    state_t               w_next_state;
    logic [3:0]           r_sel_q;
    logic                 r_next_p2;
    logic                 r_p1_turn;
    logic                 r_p2_turn;
    logic                 r_illegal;
    logic                 r_bad_sel;
    logic [NUM_CELLS-1:0] w_p1_en;
    logic [NUM_CELLS-1:0] w_p2_en;
    logic                 w_latch_sel;
    logic                 w_illegal;
    logic                 w_bad_sel;
    logic                 w_sel_valid;

    commit_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_commit_debouncer (
        .clk          (clk),
        .reset        (reset),
        .commit       (commit),
        .commit_pulse (w_commit_pulse)
    );

    assign w_sel_valid = (cell_sel <= MAX_CELL);

    always_comb begin
        w_next_state = r_state;
        w_p1_en      = '0;
        w_p2_en      = '0;
        w_latch_sel  = 1'b0;
        w_illegal    = 1'b0;
        w_bad_sel    = 1'b0;
        case (r_state)
            P1_TURN, P2_TURN: begin
                if (w_commit_pulse) begin
                    if (w_sel_valid) begin
                        w_latch_sel  = 1'b1;
                        w_next_state = (r_state == P1_TURN) ? ISSUE1 : ISSUE2;
                    end else begin
                        w_bad_sel = 1'b1;
                    end
                end
            end
            ISSUE1: begin
                w_p1_en = cell_onehot(r_sel_q);
                // A rejected move returns to the same player; the board blocks the write.
                w_illegal    = ill_move;
                w_next_state = ill_move ? P1_TURN : CHECK;
            end
            ISSUE2: begin
                w_p2_en      = cell_onehot(r_sel_q);
                w_illegal    = ill_move;
                w_next_state = ill_move ? P2_TURN : CHECK;
            end
            CHECK: begin
                if (win || no_space) begin
                    w_next_state = GAME_OVER;
                end else begin
                    w_next_state = r_next_p2 ? P2_TURN : P1_TURN;
                end
            end
            GAME_OVER: w_next_state = GAME_OVER;
            default:   w_next_state = P1_TURN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= P1_TURN;
            r_sel_q   <= 4'd0;
            r_next_p2 <= 1'b0;
            r_p1_turn <= 1'b1;
            r_p2_turn <= 1'b0;
            r_illegal <= 1'b0;
            r_bad_sel <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_illegal <= w_illegal;
            r_bad_sel <= w_bad_sel;
            if (w_latch_sel) begin
                r_sel_q <= cell_sel;
            end
            if (r_state == ISSUE1 && !ill_move) begin
                r_next_p2 <= 1'b1;
            end else if (r_state == ISSUE2 && !ill_move) begin
                r_next_p2 <= 1'b0;
            end
            // Turn flags hold through ISSUE/CHECK and change only on arrival.
            case (w_next_state)
                P1_TURN: begin
                    r_p1_turn <= 1'b1;
                    r_p2_turn <= 1'b0;
                end
                P2_TURN: begin
                    r_p1_turn <= 1'b0;
                    r_p2_turn <= 1'b1;
                end
                GAME_OVER: begin
                    r_p1_turn <= 1'b0;
                    r_p2_turn <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign p1_en     = w_p1_en;
    assign p2_en     = w_p2_en;
    assign p1_turn   = r_p1_turn;
    assign p2_turn   = r_p2_turn;
    assign game_over = (r_state == GAME_OVER);
    assign illegal   = r_illegal;
    assign bad_sel   = r_bad_sel;

endmodule
`default_nettype wire

// File: tb/tb_turn_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_turn_sequencer
// Description : Directed + randomized bench for turn_sequencer against a
//               behavioural game model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_turn_sequencer;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cell_sel = 4'd0;
    logic       commit = 1'b0;
    logic       ill_move = 1'b0;
    logic       win = 1'b0;
    logic       no_space = 1'b0;
    logic [8:0] p1_en;
    logic [8:0] p2_en;
    logic       p1_turn;
    logic       p2_turn;
    logic       game_over;
    logic       illegal;
    logic       bad_sel;

    always #5 clk = ~clk;

    turn_sequencer #(
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cell_sel  (cell_sel),
        .commit    (commit),
        .ill_move  (ill_move),
        .win       (win),
        .no_space  (no_space),
        .p1_en     (p1_en),
        .p2_en     (p2_en),
        .p1_turn   (p1_turn),
        .p2_turn   (p2_turn),
        .game_over (game_over),
        .illegal   (illegal),
        .bad_sel   (bad_sel)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int en_seen, ill_seen, bad_seen;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: raw switch -> delayed sample -> stable-run debounce -> game rules
    bit m_s1, m_s2, m_lvl, m_pulse;
    bit m_run[$];
    bit m_over, m_issuing, m_checking, m_illegal, m_bad;
    int m_player, m_cell;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_lvl = 0; m_pulse = 0;
        m_run.delete();
        m_over = 0; m_issuing = 0; m_checking = 0; m_illegal = 0; m_bad = 0;
        m_player = 0; m_cell = 0;
    endtask

    task automatic model_edge();
        bit seen;
        bit press;
        seen  = m_s2;
        press = m_pulse;
        m_s2 = m_s1;
        m_s1 = commit;
        m_pulse = 0;
        if (seen == m_lvl) begin
            m_run.delete();
        end else begin
            m_run.push_back(seen);
            if (m_run.size() == DC) begin
                m_lvl = seen;
                m_pulse = seen;
                m_run.delete();
            end
        end
        m_illegal = 0;
        m_bad = 0;
        if (m_over) begin
        end else if (m_checking) begin
            m_checking = 0;
            if (win || no_space) m_over = 1;
            else m_player = 1 - m_player;
        end else if (m_issuing) begin
            m_issuing = 0;
            if (ill_move) m_illegal = 1;
            else m_checking = 1;
        end else if (press) begin
            if (cell_sel <= 4'd8) begin
                m_issuing = 1;
                m_cell = int'(cell_sel);
            end else begin
                m_bad = 1;
            end
        end
    endtask

    function automatic logic [22:0] model_outs();
        logic [8:0] e1, e2, one;
        one = 9'd1;
        e1 = '0;
        e2 = '0;
        if (m_issuing && m_player == 0) e1 = one << m_cell;
        if (m_issuing && m_player == 1) e2 = one << m_cell;
        return {e1, e2, !m_over && m_player == 0, !m_over && m_player == 1,
                m_over, m_illegal, m_bad};
    endfunction

    function automatic logic [22:0] dut_outs();
        return {p1_en, p2_en, p1_turn, p2_turn, game_over, illegal, bad_sel};
    endfunction

    task automatic step(input logic c, input logic [3:0] sel, input logic ill,
                        input logic w, input logic ns);
        @(negedge clk);
        commit = c; cell_sel = sel; ill_move = ill; win = w; no_space = ns;
        @(posedge clk);
        model_edge();
        #1;
        check_val("outs", 32'(dut_outs()), 32'(model_outs()));
        if (p1_en != 0 || p2_en != 0) en_seen++;
        if (illegal) ill_seen++;
        if (bad_sel) bad_seen++;
    endtask

    task automatic press(input logic [3:0] sel, input logic ill, input logic w, input int n);
        for (int i = 0; i < n; i++) step(1'b1, sel, ill, w, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, sel, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; commit = 1'b0; ill_move = 1'b0; win = 1'b0; no_space = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        check_val("after_reset", 32'(dut_outs()), 32'(model_outs()));
    endtask

    int  seg_left;
    bit  rc;
    int  over_cycles;
    bit  found;

    initial begin
        model_reset();
        do_reset();
        check_val("reset_state", 32'(dut_outs()), 32'({9'd0, 9'd0, 5'b10000}));

        // Held commit yields exactly one move
        en_seen = 0;
        for (int i = 0; i < 14; i++) step(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
        check_val("hold_one_move", 32'(en_seen), 32'd1);
        check_val("p2_turn_after_move", 32'(p2_turn), 32'd1);
        for (int i = 0; i < 8; i++) step(1'b0, 4'd4, 1'b0, 1'b0, 1'b0);

        // Chatter never reaches the debounce threshold
        en_seen = 0;
        for (int i = 0; i < 20; i++) step(1'((i / 2) % 2), 4'd4, 1'b0, 1'b0, 1'b0);
        check_val("chatter_no_en", 32'(en_seen), 32'd0);
        press(4'd4, 1'b0, 1'b0, 12);
        check_val("chatter_then_one", 32'(en_seen), 32'd1);

        // P1 moves, then P2's move is rejected
        press(4'd0, 1'b0, 1'b0, 10);
        ill_seen = 0; en_seen = 0;
        press(4'd4, 1'b1, 1'b0, 10);
        check_val("illegal_once", 32'(ill_seen), 32'd1);
        check_val("illegal_en_once", 32'(en_seen), 32'd1);
        check_val("illegal_keeps_p2", 32'(p2_turn), 32'd1);

        // Out-of-range select
        bad_seen = 0; en_seen = 0;
        press(4'd12, 1'b0, 1'b0, 10);
        check_val("bad_sel_once", 32'(bad_seen), 32'd1);
        check_val("bad_sel_no_en", 32'(en_seen), 32'd0);
        check_val("bad_sel_keeps_p2", 32'(p2_turn), 32'd1);

        // Winning move freezes play
        press(4'd5, 1'b0, 1'b1, 10);
        check_val("game_over", 32'({game_over, p1_turn, p2_turn}), 32'b100);
        en_seen = 0;
        press(4'd6, 1'b0, 1'b0, 10);
        press(4'd7, 1'b0, 1'b0, 10);
        check_val("frozen_no_en", 32'(en_seen), 32'd0);

        // Asynchronous reset in the middle of ISSUE1
        do_reset();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
            if (p1_en != 0) found = 1;
        end
        check_val("issue_reached", 32'(found), 32'd1);
        reset = 1'b1;
        commit = 1'b0;
        #1;
        check_val("async_rst_en", 32'({p1_en, p2_en}), 32'd0);
        check_val("async_rst_turn", 32'({p1_turn, p2_turn, game_over}), 32'b100);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        check_val("async_rst_release", 32'(dut_outs()), 32'(model_outs()));

        // Random play
        seg_left = 0; rc = 0; over_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] sel;
            if (seg_left == 0) begin
                rc = ~rc;
                seg_left = $urandom_range(1, 12);
            end
            seg_left--;
            sel = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            step(rc, sel, ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 24) == 0));
            over_cycles = game_over ? over_cycles + 1 : 0;
            if (over_cycles > 20) begin
                do_reset();
                over_cycles = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
